// File: rtl/mux4_pkg.sv
// Shared types and constants for the four-way round-robin output mux.
package mux4_pkg;

  localparam int unsigned NumReq = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_e;

endpackage

// File: rtl/mux4_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping 3->0.
module mux4_rr_pick
  import mux4_pkg::*;
(
  input  logic [NumReq-1:0] req,
  input  sel_t              last,
  output sel_t              winner,
  output logic              any
);

  sel_t idx;

  always_comb begin
    winner = last;
    any    = 1'b0;
    idx    = '0;
    // Offsets 1..4 visit every requester once, ending with 'last' itself.
    for (int unsigned i = 1; i <= NumReq; i++) begin
      idx = last + sel_t'(i);
      if (!any && req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_arbiter.sv
// Four-requester round-robin mux with a one-word registered output stage.
// Optional per-requester saturating grant counters under MUX4_ARBITER_CNT_EN.
module mux4_arbiter
  import mux4_pkg::*;
#(
  parameter int unsigned Width = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_i,
  input  logic [Width-1:0]        a_i,
  input  logic [Width-1:0]        b_i,
  input  logic [Width-1:0]        c_i,
  input  logic [Width-1:0]        d_i,
  input  logic                    y_ready_i,
  output logic [NumReq-1:0]       ack_o,
  output sel_t                    sel_o,
  output logic [Width-1:0]        y_o,
`ifdef MUX4_ARBITER_CNT_EN
  output logic [NumReq-1:0][15:0] grant_cnt_o,
`endif
  output logic                    y_valid_o
);

  state_e           state_q, state_d;
  sel_t             last_q;
  sel_t             winner;
  logic             any;
  logic             capture;
  logic [Width-1:0] win_data;

  mux4_rr_pick u_pick (
    .req    (req_i),
    .last   (last_q),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    win_data = a_i;
    case (winner)
      2'd0:    win_data = a_i;
      2'd1:    win_data = b_i;
      2'd2:    win_data = c_i;
      default: win_data = d_i;
    endcase
  end

  always_comb begin
    capture = any && ((state_q == IDLE) || y_ready_i);
    // Gate with rst_ni so no requester sees an ack while reset is held.
    ack_o   = '0;
    if (capture && rst_ni) begin
      ack_o[winner] = 1'b1;
    end
    state_d = state_q;
    if (capture) begin
      state_d = FULL;
    end else if ((state_q == FULL) && y_ready_i) begin
      state_d = IDLE;
    end
  end

  assign y_valid_o = (state_q == FULL);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      y_o     <= '0;
      sel_o   <= 2'b00;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      if (capture) begin
        y_o    <= win_data;
        sel_o  <= winner;
        last_q <= winner;
      end
    end
  end

`ifdef MUX4_ARBITER_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grant_cnt_o <= '0;
    end else begin
      for (int unsigned k = 0; k < NumReq; k++) begin
        if (ack_o[k] && (grant_cnt_o[k] != '1)) begin
          grant_cnt_o[k] <= grant_cnt_o[k] + 16'd1;
        end
      end
    end
  end
`endif

endmodule
